// File: rtl/vga_sync_controller.sv
// Raster timing generator and VGA pin driver.
// Scans the frame, presents active-area coordinates and a request strobe to
// the pixel colorizer, then registers the returned colour onto the DAC pins.
// HS, VS and BLANK_n are delay-matched to the colorizer latency so that all
// pins change together.
//
// Request/colour contract: there is no back-pressure. When oRequest is high
// in cycle t, oVGA_X/oVGA_Y name a visible pixel. The colorizer must present
// that pixel's colour on iRed/iGreen/iBlue in cycle t+PIPE_DLY, where it is
// sampled unconditionally. The colour reaches the pins in cycle t+PIPE_DLY+1.
module vga_sync_controller #(
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_DLY = 1
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic [3:0] iRed,
  input  logic [3:0] iGreen,
  input  logic [3:0] iBlue,
  output logic [9:0] oVGA_X,
  output logic [8:0] oVGA_Y,
  output logic       oRequest,
  output logic       oFrame_Start,
  output logic [3:0] oVGA_R,
  output logic [3:0] oVGA_G,
  output logic [3:0] oVGA_B,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oBLANK_n
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_C   = 10'(H_ACT);
  localparam logic [9:0] V_ACT_C   = 10'(V_ACT);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_START  = 10'(H_ACT + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACT + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACT + V_FP + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       act;
  logic       hs_n;
  logic       vs_n;

  // Sync/active flags aligned with the coordinate outputs (cycle t).
  logic       act_q;
  logic       hs_q;
  logic       vs_q;

  // Delay line: stage k holds the cycle t+k+1 view of the flags.
  logic [PIPE_DLY-1:0] act_dl;
  logic [PIPE_DLY-1:0] hs_dl;
  logic [PIPE_DLY-1:0] vs_dl;

  assign h_wrap = (h_cnt == H_LAST);

  // Decode the raster regions from the free-running counters.
  always_comb begin
    act  = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    hs_n = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vs_n = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  end

  // Horizontal and vertical scan counters; both wrap on the same edge at frame end.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Registered coordinate/request outputs plus the flags that travel with them.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oVGA_X       <= '0;
      oVGA_Y       <= '0;
      oRequest     <= 1'b0;
      oFrame_Start <= 1'b0;
      act_q        <= 1'b0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
    end else begin
      oVGA_X       <= act ? h_cnt : '0;
      oVGA_Y       <= act ? v_cnt[8:0] : '0;
      oRequest     <= act;
      oFrame_Start <= (h_cnt == '0) && (v_cnt == '0);
      act_q        <= act;
      hs_q         <= hs_n;
      vs_q         <= vs_n;
    end
  end

  // Match the flags to the colorizer latency.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      act_dl <= '0;
      hs_dl  <= '1;
      vs_dl  <= '1;
    end else begin
      act_dl[0] <= act_q;
      hs_dl[0]  <= hs_q;
      vs_dl[0]  <= vs_q;
      for (int i = 1; i < PIPE_DLY; i++) begin
        act_dl[i] <= act_dl[i-1];
        hs_dl[i]  <= hs_dl[i-1];
        vs_dl[i]  <= vs_dl[i-1];
      end
    end
  end

  // Pin stage: pass colour through while active, force black while blanked.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oVGA_R   <= '0;
      oVGA_G   <= '0;
      oVGA_B   <= '0;
      oBLANK_n <= 1'b0;
      oVGA_HS  <= 1'b1;
      oVGA_VS  <= 1'b1;
    end else begin
      if (act_dl[PIPE_DLY-1]) begin
        oVGA_R <= iRed;
        oVGA_G <= iGreen;
        oVGA_B <= iBlue;
      end else begin
        oVGA_R <= '0;
        oVGA_G <= '0;
        oVGA_B <= '0;
      end
      oBLANK_n <= act_dl[PIPE_DLY-1];
      oVGA_HS  <= hs_dl[PIPE_DLY-1];
      oVGA_VS  <= vs_dl[PIPE_DLY-1];
    end
  end

endmodule
